// File: rtl/zorro_pkg.sv
// Shared constants and types for the Zorro II AutoConfig responder.
// Nibble indices are A[6:1] within the $E8xxxx config page.
package zorro_pkg;

    localparam logic [7:0] CFG_PAGE = 8'hE8;

    localparam logic [5:0] NIB_ER_TYPE = 6'd0;
    localparam logic [5:0] NIB_PRODUCT = 6'd2;
    localparam logic [5:0] NIB_MANUF   = 6'd8;
    localparam logic [5:0] NIB_SERIAL  = 6'd12;
    localparam logic [5:0] NIB_CTRL    = 6'd32;
    localparam logic [5:0] NIB_BASE_HI = 6'd36;
    localparam logic [5:0] NIB_BASE_LO = 6'd37;
    localparam logic [5:0] NIB_SHUTUP  = 6'd38;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StAck
    } state_e;

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig read map: nibble index to bus nibble on D[31:28].
// Everything except er_type and the $40/$42 control nibbles is presented inverted.
module autoconfig_rom
    import zorro_pkg::*;
#(
    parameter logic [7:0]  ER_TYPE      = 8'hE6,
    parameter logic [7:0]  PRODUCT      = 8'h3C,
    parameter logic [15:0] MANUFACTURER = 16'h07DB,
    parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
    input  logic [5:0] nib_i,
    output logic [3:0] dout_o
);

    logic [3:0] val;
    logic       raw;

    always_comb begin
        val = 4'h0;
        case (nib_i)
            NIB_ER_TYPE:         val = ER_TYPE[7:4];
            NIB_ER_TYPE + 6'd1:  val = ER_TYPE[3:0];
            NIB_PRODUCT:         val = PRODUCT[7:4];
            NIB_PRODUCT + 6'd1:  val = PRODUCT[3:0];
            NIB_MANUF:           val = MANUFACTURER[15:12];
            NIB_MANUF + 6'd1:    val = MANUFACTURER[11:8];
            NIB_MANUF + 6'd2:    val = MANUFACTURER[7:4];
            NIB_MANUF + 6'd3:    val = MANUFACTURER[3:0];
            NIB_SERIAL:          val = SERIAL[31:28];
            NIB_SERIAL + 6'd1:   val = SERIAL[27:24];
            NIB_SERIAL + 6'd2:   val = SERIAL[23:20];
            NIB_SERIAL + 6'd3:   val = SERIAL[19:16];
            NIB_SERIAL + 6'd4:   val = SERIAL[15:12];
            NIB_SERIAL + 6'd5:   val = SERIAL[11:8];
            NIB_SERIAL + 6'd6:   val = SERIAL[7:4];
            NIB_SERIAL + 6'd7:   val = SERIAL[3:0];
            default:             val = 4'h0;
        endcase
    end

    assign raw = (nib_i == NIB_ER_TYPE) || (nib_i == NIB_ER_TYPE + 6'd1) ||
                 (nib_i == NIB_CTRL)    || (nib_i == NIB_CTRL + 6'd1);

    assign dout_o = raw ? val : ~val;

endmodule

// File: rtl/autoconfig_responder.sv
// Zorro II AutoConfig responder: decodes the $E8 config page, serves the ROM
// nibbles and latches the base address; CFGOUT enables the next board in the chain.
module autoconfig_responder
    import zorro_pkg::*;
#(
    parameter logic [7:0]  ER_TYPE      = 8'hE6,
    parameter logic [7:0]  PRODUCT      = 8'h3C,
    parameter logic [15:0] MANUFACTURER = 16'h07DB,
    parameter logic [31:0] SERIAL       = 32'h0000_0001
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW20,
    input  logic [23:0] A,
    input  logic [3:0]  D_IN,
    input  logic        CFGIN,
    output logic [3:0]  D_OUT,
    output logic        D_OE,
    output logic        ACK,
    output logic [7:0]  BASE,
    output logic        CONFIGURED,
    output logic        SHUTUP,
    output logic        CFGOUT
);

    state_e     state_q, state_d;
    logic       rw_q, rw_d;
    logic [5:0] nib_q, nib_d;
    logic [3:0] dout_q, dout_d;
    logic [7:0] base_q, base_d;
    logic       pend_cfg_q, pend_cfg_d;
    logic       pend_shut_q, pend_shut_d;
    logic       configured_q, configured_d;
    logic       shutup_q, shutup_d;

    logic       sel;
    logic [3:0] rom_dout;

    // The page mirrors every 128 bytes; these address bits never take part.
    logic unused_addr;
    assign unused_addr = ^{A[15:7], A[0]};

    autoconfig_rom #(
        .ER_TYPE      (ER_TYPE),
        .PRODUCT      (PRODUCT),
        .MANUFACTURER (MANUFACTURER),
        .SERIAL       (SERIAL)
    ) u_rom (
        .nib_i  (A[6:1]),
        .dout_o (rom_dout)
    );

    assign sel = !AS20 && (A[23:16] == CFG_PAGE) && CFGIN && !configured_q && !shutup_q;

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        nib_d        = nib_q;
        dout_d       = dout_q;
        base_d       = base_q;
        pend_cfg_d   = pend_cfg_q;
        pend_shut_d  = pend_shut_q;
        configured_d = configured_q;
        shutup_d     = shutup_q;

        case (state_q)
            StIdle: begin
                if (sel) begin
                    state_d = StDecode;
                    nib_d   = A[6:1];
                    rw_d    = RW20;
                    dout_d  = rom_dout;
                end
            end
            StDecode: begin
                if (AS20) begin
                    state_d = StIdle;
                end else if (rw_q) begin
                    state_d = StAck;
                end else if (!DS20) begin
                    state_d = StAck;
                    case (nib_q)
                        NIB_BASE_LO: base_d[3:0] = D_IN;
                        NIB_BASE_HI: begin
                            base_d[7:4] = D_IN;
                            pend_cfg_d  = 1'b1;
                        end
                        NIB_SHUTUP:  pend_shut_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            StAck: begin
                // Commit only at cycle end so sel cannot drop while ACK is driven.
                if (AS20) begin
                    state_d      = StIdle;
                    configured_d = configured_q | pend_cfg_q;
                    shutup_d     = shutup_q | pend_shut_q;
                    pend_cfg_d   = 1'b0;
                    pend_shut_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            rw_q         <= 1'b1;
            nib_q        <= 6'd0;
            dout_q       <= 4'hF;
            base_q       <= 8'h00;
            pend_cfg_q   <= 1'b0;
            pend_shut_q  <= 1'b0;
            configured_q <= 1'b0;
            shutup_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            nib_q        <= nib_d;
            dout_q       <= dout_d;
            base_q       <= base_d;
            pend_cfg_q   <= pend_cfg_d;
            pend_shut_q  <= pend_shut_d;
            configured_q <= configured_d;
            shutup_q     <= shutup_d;
        end
    end

    assign ACK        = (state_q == StAck);
    assign D_OE       = (state_q == StAck) && rw_q;
    assign D_OUT      = dout_q;
    assign BASE       = base_q;
    assign CONFIGURED = configured_q;
    assign SHUTUP     = shutup_q;
    assign CFGOUT     = configured_q | shutup_q;

endmodule

// File: tb/tb_autoconfig_responder.sv
// Bench for autoconfig_responder: two chained instances on one bus, table-driven
// config cycles checked through a scoreboard, plus abort/reset/shutup sequences.
module tb_autoconfig_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        as20, ds20, rw20;
    logic [23:0] a;
    logic [3:0]  d_in;
    logic        cfgin0;

    logic [3:0]  d_out0, d_out1;
    logic        d_oe0, d_oe1, ack0, ack1, conf0, conf1, shut0, shut1, cfgout0, cfgout1;
    logic [7:0]  base0, base1;

    int n_tests = 0;
    int n_fail  = 0;
    int ack0_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ack0) ack0_count <= ack0_count + 1;

    autoconfig_responder u_dut0 (
        .CLKCPU(clk), .RESET(rst), .AS20(as20), .DS20(ds20), .RW20(rw20), .A(a),
        .D_IN(d_in), .CFGIN(cfgin0), .D_OUT(d_out0), .D_OE(d_oe0), .ACK(ack0),
        .BASE(base0), .CONFIGURED(conf0), .SHUTUP(shut0), .CFGOUT(cfgout0)
    );

    autoconfig_responder u_dut1 (
        .CLKCPU(clk), .RESET(rst), .AS20(as20), .DS20(ds20), .RW20(rw20), .A(a),
        .D_IN(d_in), .CFGIN(cfgout0), .D_OUT(d_out1), .D_OE(d_oe1), .ACK(ack1),
        .BASE(base1), .CONFIGURED(conf1), .SHUTUP(shut1), .CFGOUT(cfgout1)
    );

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic [3:0]  wdata;
        logic [3:0]  exp_dout;
        logic [7:0]  exp_base;
        logic        exp_conf;
    } vec_t;

    typedef struct {
        int         idx;
        logic       rw;
        logic [3:0] exp_dout;
        logic [7:0] exp_base;
        logic       exp_conf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic ack_of(input int dut);
        return (dut == 0) ? ack0 : ack1;
    endfunction
    function automatic logic [3:0] dout_of(input int dut);
        return (dut == 0) ? d_out0 : d_out1;
    endfunction
    function automatic logic oe_of(input int dut);
        return (dut == 0) ? d_oe0 : d_oe1;
    endfunction
    function automatic logic conf_of(input int dut);
        return (dut == 0) ? conf0 : conf1;
    endfunction
    function automatic logic cfgout_of(input int dut);
        return (dut == 0) ? cfgout0 : cfgout1;
    endfunction

    // One bus cycle; ack_edge counts rising edges after AS20 falls (0 = no ACK).
    task automatic bus_cycle(input logic [23:0] addr, input logic rw, input logic [3:0] wdata,
                             input int dut, output int ack_edge, output logic [3:0] dout_seen,
                             output logic oe_seen, output logic conf_pre, output logic ack_post,
                             output logic conf_post, output logic cfgout_post);
        ack_edge  = 0;
        dout_seen = 4'h0;
        oe_seen   = 1'b0;
        @(negedge clk);
        a = addr; rw20 = rw; d_in = wdata; as20 = 1'b0; ds20 = 1'b0;
        for (int k = 1; k <= 8 && ack_edge == 0; k++) begin
            @(posedge clk); #1;
            if (ack_of(dut)) begin
                ack_edge  = k;
                dout_seen = dout_of(dut);
                oe_seen   = oe_of(dut);
            end
        end
        @(negedge clk);
        as20 = 1'b1; ds20 = 1'b1;
        conf_pre = conf_of(dut);
        @(posedge clk); #1;
        ack_post    = ack_of(dut);
        conf_post   = conf_of(dut);
        cfgout_post = cfgout_of(dut);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; as20 = 1'b1; ds20 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int         ae;
    logic [3:0] dv;
    logic       oe, cpre, apost, cpost, opost;
    exp_t       e;
    int         cnt0;
    logic       seen;

    initial begin
        rst = 1'b1; as20 = 1'b1; ds20 = 1'b1; rw20 = 1'b1; a = '0; d_in = '0; cfgin0 = 1'b1;

        vecs[0]  = '{24'hE80000, 1'b1, 4'h0, 4'hE, 8'h00, 1'b0};
        vecs[1]  = '{24'hE80002, 1'b1, 4'h0, 4'h6, 8'h00, 1'b0};
        vecs[2]  = '{24'hE80004, 1'b1, 4'h0, 4'hC, 8'h00, 1'b0};
        vecs[3]  = '{24'hE80006, 1'b1, 4'h0, 4'h3, 8'h00, 1'b0};
        vecs[4]  = '{24'hE80010, 1'b1, 4'h0, 4'hF, 8'h00, 1'b0};
        vecs[5]  = '{24'hE80016, 1'b1, 4'h0, 4'h4, 8'h00, 1'b0};
        vecs[6]  = '{24'hE80018, 1'b1, 4'h0, 4'hF, 8'h00, 1'b0};
        vecs[7]  = '{24'hE80026, 1'b1, 4'h0, 4'hE, 8'h00, 1'b0};
        vecs[8]  = '{24'hE80040, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0};
        vecs[9]  = '{24'hE80042, 1'b1, 4'h0, 4'h0, 8'h00, 1'b0};
        vecs[10] = '{24'hE8007E, 1'b1, 4'h0, 4'hF, 8'h00, 1'b0};
        vecs[11] = '{24'hE80081, 1'b1, 4'h0, 4'hE, 8'h00, 1'b0};
        vecs[12] = '{24'hE8004A, 1'b0, 4'h9, 4'h0, 8'h09, 1'b0};
        vecs[13] = '{24'hE80048, 1'b0, 4'hE, 4'h0, 8'hE9, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset d_out", d_out0, 4'hF);
        check("reset d_oe", d_oe0, 1'b0);
        check("reset ack", ack0, 1'b0);
        check("reset base", base0, 8'h00);
        check("reset configured", conf0, 1'b0);
        check("reset shutup", shut0, 1'b0);
        check("reset cfgout", cfgout0, 1'b0);

        foreach (vecs[i]) begin
            sb.push_back('{i, vecs[i].rw, vecs[i].exp_dout, vecs[i].exp_base, vecs[i].exp_conf});
            bus_cycle(vecs[i].addr, vecs[i].rw, vecs[i].wdata, 0, ae, dv, oe, cpre, apost, cpost,
                      opost);
            e = sb.pop_front();
            check($sformatf("vec%0d ack_edge", e.idx), ae, 2);
            check($sformatf("vec%0d d_oe", e.idx), oe, e.rw);
            if (e.rw) check($sformatf("vec%0d d_out", e.idx), dv, e.exp_dout);
            check($sformatf("vec%0d ack_fall", e.idx), apost, 1'b0);
            check($sformatf("vec%0d conf_before_neg", e.idx), cpre, 1'b0);
            check($sformatf("vec%0d configured", e.idx), cpost, e.exp_conf);
            check($sformatf("vec%0d cfgout", e.idx), opost, e.exp_conf);
            check($sformatf("vec%0d base", e.idx), base0, e.exp_base);
        end

        // First board configured: it goes quiet, the second one now answers.
        cnt0 = ack0_count;
        bus_cycle(24'hE80000, 1'b1, 4'h0, 1, ae, dv, oe, cpre, apost, cpost, opost);
        check("chain dut0 silent", ack0_count - cnt0, 0);
        check("chain dut1 ack_edge", ae, 2);
        check("chain dut1 d_out", dv, 4'hE);
        bus_cycle(24'hE8004A, 1'b0, 4'h0, 1, ae, dv, oe, cpre, apost, cpost, opost);
        bus_cycle(24'hE80048, 1'b0, 4'h2, 1, ae, dv, oe, cpre, apost, cpost, opost);
        check("chain dut1 base", base1, 8'h20);
        check("chain dut1 configured", cpost, 1'b1);
        check("chain dut0 base kept", base0, 8'hE9);
        check("chain dut0 no extra ack", ack0_count - cnt0, 0);

        // Abort: AS20 negated while DECODE still waits for DS20.
        do_reset();
        @(negedge clk);
        a = 24'hE8004A; rw20 = 1'b0; d_in = 4'h5; as20 = 1'b0; ds20 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort ack in decode", ack0, 1'b0);
        @(negedge clk);
        as20 = 1'b1;
        @(posedge clk); #1;
        check("abort ack after", ack0, 1'b0);
        check("abort base", base0, 8'h00);
        bus_cycle(24'hE80002, 1'b1, 4'h0, 0, ae, dv, oe, cpre, apost, cpost, opost);
        check("post-abort ack_edge", ae, 2);
        check("post-abort d_out", dv, 4'h6);

        // CFGIN dropping mid-cycle must not cut the cycle short.
        @(negedge clk);
        a = 24'hE80004; rw20 = 1'b1; as20 = 1'b0; ds20 = 1'b0;
        @(posedge clk); #1;
        cfgin0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(posedge clk); #1;
            if (ack0) seen = 1'b1;
        end
        check("cfgin drop ack", seen, 1'b1);
        check("cfgin drop d_out", d_out0, 4'hC);
        @(negedge clk);
        as20 = 1'b1; ds20 = 1'b1;
        @(negedge clk);
        cfgin0 = 1'b1;

        // Partial base, then RESET while ACK is held.
        bus_cycle(24'hE8004A, 1'b0, 4'h7, 0, ae, dv, oe, cpre, apost, cpost, opost);
        check("partial base", base0, 8'h07);
        check("partial configured", cpost, 1'b0);
        @(negedge clk);
        a = 24'hE80000; rw20 = 1'b1; as20 = 1'b0; ds20 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge clk); #1;
            if (ack0) seen = 1'b1;
        end
        check("pre-reset ack", seen, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset ack", ack0, 1'b0);
        check("async reset d_oe", d_oe0, 1'b0);
        check("async reset d_out", d_out0, 4'hF);
        check("async reset base", base0, 8'h00);
        check("async reset configured", conf0, 1'b0);
        check("async reset cfgout", cfgout0, 1'b0);
        @(negedge clk);
        as20 = 1'b1; ds20 = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Shut-up write.
        bus_cycle(24'hE8004C, 1'b0, 4'h0, 0, ae, dv, oe, cpre, apost, cpost, opost);
        check("shutup ack_edge", ae, 2);
        check("shutup flag", shut0, 1'b1);
        check("shutup cfgout", opost, 1'b1);
        check("shutup configured", cpost, 1'b0);
        check("shutup base", base0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
